// File: rtl/cgra_cfg_pkg.sv
// Shared definitions for the configuration-chain loader.
//   - default word width / chain length / counter widths
//   - loader FSM state encoding (plain 2-bit constants so older tools and
//     waveform viewers see the same values)
package cgra_cfg_pkg;

  localparam int CFG_WORD_W    = 12;
  localparam int CFG_CHAIN_LEN = 12;
  localparam int CFG_CNT_W     = 16;
  localparam int CFG_ERR_W     = 8;

  typedef logic [1:0] ld_state_t;

  localparam ld_state_t ST_IDLE  = 2'd0;
  localparam ld_state_t ST_LOAD  = 2'd1;
  localparam ld_state_t ST_SHIFT = 2'd2;
  localparam ld_state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/cfg_chain_loader_if.sv
// Bundle of all non-clock/reset signals of the configuration-chain loader.
//   master : load requester + tile side (drives start/num_words/word_*,
//            chain_in; observes everything else)
//   slave  : the loader itself
interface cfg_chain_loader_if #(
  parameter int WORD_W = 12,
  parameter int CNT_W  = 16,
  parameter int ERR_W  = 8
);
  logic              start;
  logic [CNT_W-1:0]  num_words;
  logic [WORD_W-1:0] word_data;
  logic              word_valid;
  logic              word_ready;
  logic              cfg_data_out;
  logic              program_mode;
  logic              chain_in;
  logic              busy;
  logic              done;
  logic [ERR_W-1:0]  err_cnt;

  modport master (
    output start, num_words, word_data, word_valid, chain_in,
    input  word_ready, cfg_data_out, program_mode, busy, done, err_cnt
  );

  modport slave (
    input  start, num_words, word_data, word_valid, chain_in,
    output word_ready, cfg_data_out, program_mode, busy, done, err_cnt
  );
endinterface

// File: rtl/cfg_echo_checker.sv
// Chain integrity checker: remembers the last CHAIN_LEN bits shifted into
// the tile and compares each returning bit with the one sent CHAIN_LEN
// shift cycles earlier.
// Ports:
//   clk, rst   clock, synchronous active-low reset
//   shift_en   a bit is on the line this cycle (history/counter advance)
//   bit_sent   bit currently driven into the chain
//   chain_in   serial return from the chain
//   clear      restart checking (new load); wins over shift_en
//   err_cnt    saturating mismatch count
module cfg_echo_checker #(
  parameter int CHAIN_LEN = 12,
  parameter int ERR_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic             bit_sent,
  input  logic             chain_in,
  input  logic             clear,
  output logic [ERR_W-1:0] err_cnt
);
  localparam int SC_W = $clog2(CHAIN_LEN + 1);
  localparam logic [SC_W-1:0] SC_FULL = SC_W'(CHAIN_LEN);

  logic [CHAIN_LEN-1:0] hist;
  logic [SC_W-1:0]      shift_cnt;

  // hist[CHAIN_LEN-1] is the bit sent CHAIN_LEN shift cycles ago, i.e. the
  // one that should be emerging from the chain right now.
  wire primed   = shift_cnt == SC_FULL;
  wire mismatch = shift_en && primed && (chain_in != hist[CHAIN_LEN-1]);

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      hist      <= '0;
      shift_cnt <= '0;
      err_cnt   <= '0;
    end else if (shift_en) begin
      hist <= (hist << 1) | CHAIN_LEN'(bit_sent);
      // count only up to the chain length: past that every cycle compares
      if (!primed) shift_cnt <= shift_cnt + SC_W'(1);
      if (mismatch && err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
    end
  end
endmodule

// File: rtl/cfg_chain_loader.sv
// Bit-serial configuration transmitter for a tile's config chain.
// Takes parallel words over valid/ready and shifts them MSB-first, one bit
// per clock, with program_mode marking every cycle that carries a bit.
// Consecutive words stream with no gap when the next word is offered on
// the last bit of the current one. The chain's serial return is checked
// against what was sent.
// Ports:
//   clk, rst   clock, synchronous active-low reset
//   bus        cfg_chain_loader_if.slave:
//                start/num_words      load request (ignored while busy)
//                word_data/valid/ready word handshake
//                cfg_data_out/program_mode  serial output to tile
//                chain_in             serial return from tile
//                busy/done/err_cnt    status
module cfg_chain_loader
  import cgra_cfg_pkg::*;
#(
  parameter int WORD_W    = CFG_WORD_W,
  parameter int CHAIN_LEN = CFG_CHAIN_LEN,
  parameter int CNT_W     = CFG_CNT_W,
  parameter int ERR_W     = CFG_ERR_W
) (
  input logic               clk,
  input logic               rst,
  cfg_chain_loader_if.slave bus
);
  localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [BIT_W-1:0] BIT_TOP = BIT_W'(WORD_W - 1);

  ld_state_t         state;
  logic [WORD_W-1:0] sreg;
  logic [BIT_W-1:0]  bit_idx;
  logic [CNT_W-1:0]  words_left;
  logic [ERR_W-1:0]  err_cnt;

  wire in_shift  = state == ST_SHIFT;
  wire last_bit  = bit_idx == '0;
  wire more      = words_left > CNT_W'(1);
  wire start_acc = (state == ST_IDLE) && bus.start;

  // All outputs decode flop state only, so they cannot glitch with inputs.
  assign bus.program_mode = in_shift;
  assign bus.cfg_data_out = in_shift && sreg[WORD_W-1];
  assign bus.word_ready   = (state == ST_LOAD) || (in_shift && last_bit && more);
  assign bus.busy         = state != ST_IDLE;
  assign bus.done         = state == ST_DONE;
  assign bus.err_cnt      = err_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      sreg       <= '0;
      bit_idx    <= '0;
      words_left <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            words_left <= bus.num_words;
            state      <= (bus.num_words != '0) ? ST_LOAD : ST_DONE;
          end
        end
        ST_LOAD: begin
          if (bus.word_valid) begin
            sreg    <= bus.word_data;
            bit_idx <= BIT_TOP;
            state   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          sreg    <= sreg << 1;
          bit_idx <= bit_idx - BIT_W'(1);
          if (last_bit) begin
            if (more) begin
              words_left <= words_left - CNT_W'(1);
              if (bus.word_valid) begin
                // back-to-back: next word's MSB goes out on the next cycle
                sreg    <= bus.word_data;
                bit_idx <= BIT_TOP;
              end else begin
                state <= ST_LOAD;
              end
            end else begin
              state <= ST_DONE;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  cfg_echo_checker #(
    .CHAIN_LEN (CHAIN_LEN),
    .ERR_W     (ERR_W)
  ) u_echo (
    .clk      (clk),
    .rst      (rst),
    .shift_en (in_shift),
    .bit_sent (sreg[WORD_W-1]),
    .chain_in (bus.chain_in),
    .clear    (start_acc),
    .err_cnt  (err_cnt)
  );
endmodule

// File: tb/tb_cfg_chain_loader.sv
// Self-checking bench for cfg_chain_loader. Expected serial bits are queued
// when words are offered and popped by a monitor on every program_mode
// cycle; a 12-flop chain model feeds chain_in.
module tb_cfg_chain_loader;
  localparam int WW = 12;
  localparam int CL = 12;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cfg_chain_loader_if #(.WORD_W(WW), .CNT_W(16), .ERR_W(8)) bus ();

  cfg_chain_loader #(.WORD_W(WW), .CHAIN_LEN(CL), .CNT_W(16), .ERR_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // tile chain model: shifts only when a bit is on the line
  logic [CL-1:0] chain = '0;
  logic inv = 1'b0;
  always @(posedge clk) if (bus.program_mode) chain <= {chain[CL-2:0], bus.cfg_data_out};
  assign bus.chain_in = chain[CL-1] ^ inv;

  logic [WW-1:0] wq[$];
  logic          exp_q[$];

  always @(negedge clk) begin
    if (rst && bus.program_mode) begin
      if (exp_q.size() == 0) chk("extra_bit", 32'(bus.cfg_data_out), 32'd2);
      else chk("bit", 32'(bus.cfg_data_out), 32'(exp_q.pop_front()));
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [WW-1:0] w);
    wq.push_back(w);
    for (int i = WW - 1; i >= 0; i--) exp_q.push_back(w[i]);
  endtask

  task automatic start_load(input int n);
    bus.num_words = 16'(n);
    bus.start     = 1'b1;
    tick;
    bus.start     = 1'b0;
  endtask

  // Step a load from the cycle after start until done. idx 0 is the first
  // cycle after the start edge.
  task automatic observe(input int ss, input int sl, input int inv_at,
                         input logic [63:0] start_mask,
                         output int pm_n, output int first_pm, output int last_pm,
                         output int done_at, output logic [63:0] rdy);
    logic acc;
    pm_n = 0; first_pm = -1; last_pm = -1; done_at = -1; rdy = '0;
    for (int i = 0; i < 64; i++) begin
      bus.word_valid = !(i >= ss && i < ss + sl) && (wq.size() > 0);
      bus.word_data  = (wq.size() > 0) ? wq[0] : '0;
      inv            = (i == inv_at);
      bus.start      = start_mask[i];
      bus.num_words  = start_mask[i] ? 16'd7 : 16'd0;
      if (bus.program_mode) begin
        pm_n++;
        if (first_pm < 0) first_pm = i;
        last_pm = i;
      end
      if (bus.word_ready) rdy[i] = 1'b1;
      acc = bus.word_valid && bus.word_ready;
      if (bus.done) begin
        done_at = i;
        tick;
        bus.start = 1'b0; bus.word_valid = 1'b0; inv = 1'b0;
        return;
      end
      tick;
      if (acc) void'(wq.pop_front());
    end
    chk("timeout", 32'd1, 32'd0);
    bus.start = 1'b0; bus.word_valid = 1'b0; inv = 1'b0;
  endtask

  int pm_n, f_pm, l_pm, d_at;
  logic [63:0] rdy;

  initial begin
    bus.start = 0; bus.num_words = '0; bus.word_data = '0; bus.word_valid = 0;
    repeat (3) tick;
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_pm", 32'(bus.program_mode), 0);
    chk("rst_ready", 32'(bus.word_ready), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_cfg", 32'(bus.cfg_data_out), 0);
    chk("rst_err", 32'(bus.err_cnt), 0);
    rst = 1'b1;
    tick;

    // single word, valid held
    push_word(12'hA5C);
    bus.word_valid = 1'b1; bus.word_data = 12'hA5C;
    start_load(1);
    observe(99, 0, -1, '0, pm_n, f_pm, l_pm, d_at, rdy);
    chk("t1_pm_n", pm_n, 12);
    chk("t1_first", f_pm, 1);
    chk("t1_last", l_pm, 12);
    chk("t1_done", d_at, 13);
    chk("t1_rdy", rdy[31:0], 32'h1);
    chk("t1_err", 32'(bus.err_cnt), 0);
    chk("t1_q", exp_q.size(), 0);

    // three words back-to-back
    push_word(12'hA5C); push_word(12'h3F0); push_word(12'h5A5);
    start_load(3);
    observe(99, 0, -1, '0, pm_n, f_pm, l_pm, d_at, rdy);
    chk("t2_pm_n", pm_n, 36);
    chk("t2_span", l_pm - f_pm + 1, 36);
    chk("t2_done", d_at, 37);
    chk("t2_rdy", rdy[31:0], 32'h0100_1001);
    chk("t2_rdy_hi", rdy[63:32], 0);
    chk("t2_err", 32'(bus.err_cnt), 0);
    chk("t2_q", exp_q.size(), 0);

    // 5-cycle stall starting on word 1's last bit
    push_word(12'h123); push_word(12'hABC);
    start_load(2);
    observe(12, 5, -1, '0, pm_n, f_pm, l_pm, d_at, rdy);
    chk("t3_pm_n", pm_n, 24);
    chk("t3_gap", (l_pm - f_pm + 1) - pm_n, 5);
    chk("t3_done", d_at, 30);
    chk("t3_q", exp_q.size(), 0);

    // echo with one corrupted return bit inside word 2
    push_word(12'hA5C); push_word(12'h3F0);
    start_load(2);
    observe(99, 0, 18, '0, pm_n, f_pm, l_pm, d_at, rdy);
    chk("t4_inv_err", 32'(bus.err_cnt), 1);

    // zero-word load: done next cycle, no program_mode, err cleared
    start_load(0);
    observe(99, 0, -1, '0, pm_n, f_pm, l_pm, d_at, rdy);
    chk("t5_done", d_at, 0);
    chk("t5_pm_n", pm_n, 0);
    chk("t5_err", 32'(bus.err_cnt), 0);

    // clean echo
    push_word(12'hA5C); push_word(12'h3F0);
    start_load(2);
    observe(99, 0, -1, '0, pm_n, f_pm, l_pm, d_at, rdy);
    chk("t6_err", 32'(bus.err_cnt), 0);
    chk("t6_pm_n", pm_n, 24);

    // start pulses mid-shift and in DONE are ignored
    push_word(12'h6E1);
    start_load(1);
    observe(99, 0, -1, (64'd1 << 5) | (64'd1 << 13), pm_n, f_pm, l_pm, d_at, rdy);
    chk("t7_pm_n", pm_n, 12);
    chk("t7_done", d_at, 13);
    chk("t7_busy", 32'(bus.busy), 0);
    tick;
    chk("t7_idle", 32'(bus.busy), 0);

    // corrupt again so the reset below has something to clear
    push_word(12'hA5C); push_word(12'h3F0);
    start_load(2);
    observe(99, 0, 20, '0, pm_n, f_pm, l_pm, d_at, rdy);
    chk("t8_inv_err", 32'(bus.err_cnt), 1);

    // reset during bit 5 of a word
    push_word(12'hC3A);
    bus.word_valid = 1'b1; bus.word_data = 12'hC3A;
    start_load(1);
    repeat (5) tick;
    chk("t9_mid_pm", 32'(bus.program_mode), 1);
    rst = 1'b0;
    tick;
    chk("t9_pm", 32'(bus.program_mode), 0);
    chk("t9_busy", 32'(bus.busy), 0);
    chk("t9_err", 32'(bus.err_cnt), 0);
    chk("t9_ready", 32'(bus.word_ready), 0);
    rst = 1'b1;
    bus.word_valid = 1'b0;
    exp_q.delete(); wq.delete();
    tick;
    push_word(12'h5A3);
    start_load(1);
    observe(99, 0, -1, '0, pm_n, f_pm, l_pm, d_at, rdy);
    chk("t9_pm_n", pm_n, 12);
    chk("t9_done", d_at, 13);
    chk("t9_q", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
